// File: rtl/tdm_i2s_master_tx.sv
// Clock-master I2S / TDM (DSP-A) serial transmitter with a one-frame holding buffer,
// valid/ready sample intake and saturating underrun counting.
module tdm_i2s_master_tx #(
    parameter int unsigned DW       = 8,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SCK_DIV  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic [CHANNELS*DW-1:0] frame_data_i,
    input  logic                   frame_valid_i,
    output logic                   frame_ready_o,
    output logic                   sck_o,
    output logic                   ws_o,
    output logic                   sd_o,
    output logic                   frame_start_o,
    output logic                   underrun_o,
    output logic [7:0]             underrun_cnt_o,
    output logic                   busy_o
);

    localparam int unsigned FRAME_BITS = CHANNELS * SLOT_W;
    localparam int unsigned DIV_W      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(FRAME_BITS / 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     started_q, started_d;
    logic                     mode_q, mode_d;
    logic [FRAME_BITS-1:0]    shift_q, shift_d;
    logic                     sck_q, sck_d;
    logic                     ws_q, ws_d;
    logic                     sd_q, sd_d;
    logic [CHANNELS*DW-1:0]   buf_q, buf_d;
    logic                     buf_full_q, buf_full_d;
    logic                     fs_q, fs_d;
    logic                     ur_q, ur_d;
    logic [7:0]               ur_cnt_q, ur_cnt_d;

    logic                     bit_evt, wrap, stop, frame_start, xfer;
    logic [FRAME_BITS-1:0]    load_vec, frame_vec;
    logic [IDX_W-1:0]         nb, nb_p1;
    logic                     nb_mode, ws_next;

    // Each slot carries its sample left-justified, channel 0 in the first slot.
    always_comb begin
        load_vec = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            load_vec[FRAME_BITS-1-k*SLOT_W -: DW] = buf_q[DW*k +: DW];
        end
    end

    assign frame_vec = buf_full_q ? load_vec : '0;

    always_comb begin
        bit_evt     = (state_q != StIdle) && (div_q == DIV_LAST);
        wrap        = !started_q || (idx_q == IDX_LAST);
        stop        = bit_evt && wrap && (state_q == StDrain) && !en_i;
        frame_start = bit_evt && wrap && !stop;
        xfer        = frame_valid_i && !buf_full_q;

        // Index and framing mode of the bit about to be driven.
        nb      = frame_start ? '0 : idx_q + IDX_W'(1);
        nb_mode = frame_start ? mode_i : mode_q;
        nb_p1   = (nb == IDX_LAST) ? '0 : nb + IDX_W'(1);
        ws_next = nb_mode ? (nb == IDX_LAST) : (nb_p1 >= IDX_HALF);

        state_d    = state_q;
        div_d      = '0;
        idx_d      = idx_q;
        started_d  = started_q;
        mode_d     = mode_q;
        shift_d    = shift_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        fs_d       = frame_start;
        ur_d       = frame_start && !buf_full_q;
        ur_cnt_d   = ur_cnt_q;

        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   if (!en_i) state_d = StDrain;
            StDrain: begin
                if (en_i) begin
                    state_d = StRun;
                end else if (stop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            div_d = bit_evt ? '0 : div_q + DIV_W'(1);
        end
        sck_d = (div_d >= DIV_HALF);

        if (stop) begin
            idx_d     = '0;
            started_d = 1'b0;
            shift_d   = '0;
            ws_d      = 1'b0;
            sd_d      = 1'b0;
        end else if (frame_start) begin
            idx_d     = '0;
            started_d = 1'b1;
            mode_d    = mode_i;
            sd_d      = frame_vec[FRAME_BITS-1];
            shift_d   = frame_vec << 1;
            ws_d      = ws_next;
        end else if (bit_evt) begin
            idx_d   = nb;
            sd_d    = shift_q[FRAME_BITS-1];
            shift_d = shift_q << 1;
            ws_d    = ws_next;
        end

        // Buffer can only be refilled while empty, so intake and a load never collide.
        if (xfer) begin
            buf_d      = frame_data_i;
            buf_full_d = 1'b1;
        end else if (frame_start && buf_full_q) begin
            buf_full_d = 1'b0;
        end

        if (ur_d && (ur_cnt_q != 8'hFF)) begin
            ur_cnt_d = ur_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            mode_q     <= 1'b0;
            shift_q    <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            mode_q     <= mode_d;
            shift_q    <= shift_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
            ur_cnt_q   <= ur_cnt_d;
        end
    end

    assign frame_ready_o  = !buf_full_q;
    assign sck_o          = sck_q;
    assign ws_o           = ws_q;
    assign sd_o           = sd_q;
    assign frame_start_o  = fs_q;
    assign underrun_o     = ur_q;
    assign underrun_cnt_o = ur_cnt_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: doc/tdm_i2s_master_tx.md
Name: tdm_i2s_master_tx

Overview:
- Parametrised, clock-master successor to the current fixed 2-channel, 8-bit, slave-clocked I2S transmitter.
- Generates SCK and WS/FS from clk and serialises CHANNELS samples of DW bits per frame, in either I2S (stereo-style) or TDM (DSP-A) framing.
- A one-frame holding buffer with a valid/ready handshake decouples the sample source (KS string, PRBS, mixer) from the serial timing.
- Underrun detection and counting are added; the counter feeds an SPI status register.

Parameters:
- DW, 8, sample width in bits (1..16).
- SLOT_W, 16, bits per channel slot; must be >= DW. Each slot carries the sample MSB-first, left-justified, then SLOT_W-DW zero bits.
- CHANNELS, 2, channels per frame (1..8); must be even in I2S mode.
- SCK_DIV, 4, clk cycles per SCK period; even, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en_i  in  1  transmit enable
- mode_i  in  1  0 = I2S framing, 1 = TDM framing; sampled only at frame start
- frame_data_i  in  CHANNELS*DW  channel k at bits [DW*(k+1)-1 : DW*k]
- frame_valid_i  in  1  frame_data_i valid
- frame_ready_o  out  1  holding buffer empty
- sck_o  out  1  serial bit clock
- ws_o  out  1  word select / frame sync
- sd_o  out  1  serial data
- frame_start_o  out  1  one-clk pulse when a frame is loaded into the shifter
- underrun_o  out  1  one-clk pulse at a frame start with an empty buffer
- underrun_cnt_o  out  8  saturating underrun count
- busy_o  out  1  frame in progress

Behaviour:
- Reset: sck_o=0, ws_o=0, sd_o=0, frame_start_o=0, underrun_o=0, underrun_cnt_o=0, busy_o=0, holding buffer empty (so frame_ready_o=1 from the first cycle after reset), all counters 0. Reset mid-frame aborts immediately; buffered data is discarded.
- FRAME_BITS = CHANNELS*SLOT_W. div_cnt counts 0..SCK_DIV-1; bit_idx counts 0..FRAME_BITS-1.
- sck_o is registered: 0 while div_cnt < SCK_DIV/2, 1 otherwise, so SCK duty cycle is 50%.
- A "bit event" is the clk edge at which div_cnt wraps to 0. On that edge sck_o falls and sd_o/ws_o update together, giving the receiver half an SCK period of setup before the rising edge.
- Handshake: frame_ready_o = buffer empty. Transfer occurs when valid && ready; the buffer becomes full on the next edge. Data is not accepted while full; valid may be held.
- Frame start is the bit event where bit_idx wraps to 0, or the first bit event after start-up.
  - Buffer full: load into the shifter, empty the buffer, pulse frame_start_o.
  - Buffer empty: load all zeros, pulse frame_start_o and underrun_o, increment underrun_cnt_o (saturates at 255).
  - A transfer on that same edge fills the buffer for the next frame and does not count as data for the current frame.
- Bit order on sd_o: channel 0 slot first, MSB-first, then channel 1, and so on.
- I2S mode: ws_o for the bit at index b equals (((b+1) mod FRAME_BITS) >= FRAME_BITS/2).
  - ws_o therefore leads data by one SCK: it is low for the left half of the frame and high for the right half.
  - The channel 0 MSB appears one SCK after ws_o falls.
- TDM mode: ws_o=1 only during bit index FRAME_BITS-1, so a one-SCK pulse precedes each frame's first bit.
- State machine IDLE / RUN / DRAIN:
  - IDLE: sck_o/ws_o/sd_o held at 0, counters held at 0, busy_o=0. The buffer still accepts data.
  - IDLE -> RUN when en_i=1. The first bit event follows SCK_DIV clk cycles later and is a frame start.
  - RUN: busy_o=1. If en_i drops, go to DRAIN.
  - DRAIN: finish the current frame. At the bit event ending bit FRAME_BITS-1, outputs go to 0 and the state returns to IDLE with no new frame start and no underrun. If en_i reasserts during DRAIN, return to RUN seamlessly.
- A mode_i change mid-frame takes effect at the next frame start only.

Test Plan:
- I2S, DW=8, SLOT_W=8, CHANNELS=2, SCK_DIV=4; load ch0=0xA5, ch1=0x3C, then en_i=1 -> sd_o per SCK = 1010_0101_0011_1100. ws_o=1 on bits 7..14 and 0 on bits 15 and 0..6. frame_start_o pulses once; underrun_cnt_o=0.
- Same configuration with no valid data and en_i=1 for 3 frames -> sd_o all 0, 3 underrun_o pulses, underrun_cnt_o=3. Forcing 300 underruns -> underrun_cnt_o=255.
- TDM, CHANNELS=4, SLOT_W=16, DW=8; ch0..3 = 0x81, 0x42, 0x24, 0x18 -> ws_o high only for the SCK before each frame. Each slot shows the 8 data bits then 8 zeros. The frame is 64 SCKs = 256 clk.
- Hold frame_valid_i high with incrementing data -> exactly one transfer per frame; no underruns after the first frame; no frame skipped or repeated.
- Drop en_i at bit 3 -> the frame completes all 16 bits, then sck_o stays 0 and busy_o=0. Assert rst_n=0 mid-frame -> all outputs 0 on the next edge and frame_ready_o=1.
- Toggle mode_i at bit 5 -> ws_o framing changes only at the next frame start.
